// File: rtl/hssl_cfg_pkt_rx.sv
// HSSL packet receiver ahead of the register bank: turns configuration packets into
// register writes and passes all other packets downstream through a 2-entry FIFO.
module hssl_cfg_pkt_rx #(
    parameter int unsigned ADR_BITS = 8,
    parameter logic [31:0] CFG_KEY  = 32'hffff_fe00,
    parameter logic [31:0] CFG_MSK  = 32'hffff_ff00
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [31:0]         pkt_key_in,
    input  logic [31:0]         pkt_data_in,
    input  logic                pkt_pld_in,
    input  logic                pkt_vld_in,
    output logic                pkt_rdy_out,

    output logic [31:0]         fwd_key_out,
    output logic [31:0]         fwd_data_out,
    output logic                fwd_pld_out,
    output logic                fwd_vld_out,
    input  logic                fwd_rdy_in,

    output logic [ADR_BITS-1:0] prx_addr_out,
    output logic [31:0]         prx_wdata_out,
    output logic                prx_en_out,

    output logic                cfg_wr_cnt_out,
    output logic                cfg_err_cnt_out,
    output logic                fwd_cnt_out
);

    localparam int unsigned CNT_W = 2;

    logic             cfg_c;
    logic             in_xfer_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt_c;

    logic [31:0]      tail_key_q;
    logic [31:0]      tail_data_q;
    logic             tail_pld_q;

    // Classification and FIFO occupancy update.
    always_comb begin
        cfg_c       = ((pkt_key_in & CFG_MSK) == (CFG_KEY & CFG_MSK));
        in_xfer_c   = pkt_vld_in && pkt_rdy_out;
        push_c      = in_xfer_c && !cfg_c;
        pop_c       = fwd_vld_out && fwd_rdy_in;
        count_nxt_c = count_q;
        if (push_c && !pop_c) begin
            count_nxt_c = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_nxt_c = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q         <= '0;
            pkt_rdy_out     <= 1'b1;
            fwd_key_out     <= '0;
            fwd_data_out    <= '0;
            fwd_pld_out     <= 1'b0;
            fwd_vld_out     <= 1'b0;
            tail_key_q      <= '0;
            tail_data_q     <= '0;
            tail_pld_q      <= 1'b0;
            prx_addr_out    <= '0;
            prx_wdata_out   <= '0;
            prx_en_out      <= 1'b0;
            cfg_wr_cnt_out  <= 1'b0;
            cfg_err_cnt_out <= 1'b0;
            fwd_cnt_out     <= 1'b0;
        end else begin
            count_q     <= count_nxt_c;
            fwd_vld_out <= (count_nxt_c != CNT_W'(0));
            pkt_rdy_out <= (count_nxt_c != CNT_W'(2));

            // Head loads from the input when it is (or is about to be) the only entry.
            if (push_c && ((count_q == CNT_W'(0)) || ((count_q == CNT_W'(1)) && pop_c))) begin
                fwd_key_out  <= pkt_key_in;
                fwd_data_out <= pkt_data_in;
                fwd_pld_out  <= pkt_pld_in;
            end else if (pop_c && (count_q == CNT_W'(2))) begin
                fwd_key_out  <= tail_key_q;
                fwd_data_out <= tail_data_q;
                fwd_pld_out  <= tail_pld_q;
            end

            if (push_c && !pop_c && (count_q == CNT_W'(1))) begin
                tail_key_q  <= pkt_key_in;
                tail_data_q <= pkt_data_in;
                tail_pld_q  <= pkt_pld_in;
            end

            prx_en_out      <= in_xfer_c && cfg_c && pkt_pld_in;
            cfg_wr_cnt_out  <= in_xfer_c && cfg_c && pkt_pld_in;
            cfg_err_cnt_out <= in_xfer_c && cfg_c && !pkt_pld_in;
            fwd_cnt_out     <= pop_c;
            if (in_xfer_c && cfg_c && pkt_pld_in) begin
                prx_addr_out  <= pkt_key_in[ADR_BITS-1:0];
                prx_wdata_out <= pkt_data_in;
            end
        end
    end

endmodule

// File: tb/tb_hssl_cfg_pkt_rx.sv
// Directed self-checking bench for hssl_cfg_pkt_rx: config writes, forwarding,
// back-pressure, stalled config packets and mid-operation reset.
module tb_hssl_cfg_pkt_rx;

    logic        clk;
    logic        reset;
    logic [31:0] pkt_key_in;
    logic [31:0] pkt_data_in;
    logic        pkt_pld_in;
    logic        pkt_vld_in;
    logic        pkt_rdy_out;
    logic [31:0] fwd_key_out;
    logic [31:0] fwd_data_out;
    logic        fwd_pld_out;
    logic        fwd_vld_out;
    logic        fwd_rdy_in;
    logic [7:0]  prx_addr_out;
    logic [31:0] prx_wdata_out;
    logic        prx_en_out;
    logic        cfg_wr_cnt_out;
    logic        cfg_err_cnt_out;
    logic        fwd_cnt_out;

    int errors = 0;
    int checks = 0;

    hssl_cfg_pkt_rx dut (
        .clk             (clk),
        .reset           (reset),
        .pkt_key_in      (pkt_key_in),
        .pkt_data_in     (pkt_data_in),
        .pkt_pld_in      (pkt_pld_in),
        .pkt_vld_in      (pkt_vld_in),
        .pkt_rdy_out     (pkt_rdy_out),
        .fwd_key_out     (fwd_key_out),
        .fwd_data_out    (fwd_data_out),
        .fwd_pld_out     (fwd_pld_out),
        .fwd_vld_out     (fwd_vld_out),
        .fwd_rdy_in      (fwd_rdy_in),
        .prx_addr_out    (prx_addr_out),
        .prx_wdata_out   (prx_wdata_out),
        .prx_en_out      (prx_en_out),
        .cfg_wr_cnt_out  (cfg_wr_cnt_out),
        .cfg_err_cnt_out (cfg_err_cnt_out),
        .fwd_cnt_out     (fwd_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] k, input logic [31:0] d, input logic p, input logic v);
        pkt_key_in  = k;
        pkt_data_in = d;
        pkt_pld_in  = p;
        pkt_vld_in  = v;
    endtask

    initial begin
        reset      = 1'b1;
        fwd_rdy_in = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("rst_rdy",     32'(pkt_rdy_out),   32'd1);
        chk("rst_fwd_vld", 32'(fwd_vld_out),   32'd0);
        chk("rst_prx_en",  32'(prx_en_out),    32'd0);
        chk("rst_addr",    32'(prx_addr_out),  32'd0);
        chk("rst_wdata",   prx_wdata_out,      32'd0);
        chk("rst_fwd_key", fwd_key_out,        32'd0);
        reset = 1'b0;
        cyc();

        // 1: configuration write
        drive(32'hffff_fe03, 32'h0000_0040, 1'b1, 1'b1);
        cyc();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t1_en",     32'(prx_en_out),     32'd1);
        chk("t1_addr",   32'(prx_addr_out),   32'h03);
        chk("t1_wdata",  prx_wdata_out,       32'h40);
        chk("t1_wrcnt",  32'(cfg_wr_cnt_out), 32'd1);
        chk("t1_fwdvld", 32'(fwd_vld_out),    32'd0);
        cyc();
        chk("t1_en_off",   32'(prx_en_out),     32'd0);
        chk("t1_addr_hold", 32'(prx_addr_out),  32'h03);
        chk("t1_wrcnt_off", 32'(cfg_wr_cnt_out), 32'd0);

        // 2: forwarded packet
        drive(32'h1234_0001, 32'hdead_beef, 1'b1, 1'b1);
        cyc();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t2_vld",  32'(fwd_vld_out), 32'd1);
        chk("t2_key",  fwd_key_out,      32'h1234_0001);
        chk("t2_data", fwd_data_out,     32'hdead_beef);
        chk("t2_pld",  32'(fwd_pld_out), 32'd1);
        chk("t2_en",   32'(prx_en_out),  32'd0);
        chk("t2_cnt0", 32'(fwd_cnt_out), 32'd0);
        cyc();
        chk("t2_cnt",    32'(fwd_cnt_out), 32'd1);
        chk("t2_vld_off", 32'(fwd_vld_out), 32'd0);
        cyc();
        chk("t2_cnt_off", 32'(fwd_cnt_out), 32'd0);

        // 3: configuration packet without payload
        drive(32'hffff_fe05, 32'h5555_5555, 1'b0, 1'b1);
        cyc();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t3_err",  32'(cfg_err_cnt_out), 32'd1);
        chk("t3_en",   32'(prx_en_out),      32'd0);
        chk("t3_vld",  32'(fwd_vld_out),     32'd0);
        chk("t3_addr", 32'(prx_addr_out),    32'h03);
        cyc();
        chk("t3_err_off", 32'(cfg_err_cnt_out), 32'd0);

        // 4: back-pressure with A, B, C
        fwd_rdy_in = 1'b0;
        drive(32'h0000_000a, 32'h1111_1111, 1'b1, 1'b1);
        cyc();
        chk("t4_a_vld", 32'(fwd_vld_out), 32'd1);
        chk("t4_a_key", fwd_key_out,      32'h0000_000a);
        chk("t4_a_rdy", 32'(pkt_rdy_out), 32'd1);
        drive(32'h0000_000b, 32'h2222_2222, 1'b0, 1'b1);
        cyc();
        chk("t4_full_rdy", 32'(pkt_rdy_out), 32'd0);
        drive(32'h0000_000c, 32'h3333_3333, 1'b1, 1'b1);
        cyc();
        chk("t4_c_held_rdy", 32'(pkt_rdy_out), 32'd0);
        cyc();
        chk("t4_hold_key",  fwd_key_out,      32'h0000_000a);
        chk("t4_hold_data", fwd_data_out,     32'h1111_1111);
        chk("t4_hold_cnt",  32'(fwd_cnt_out), 32'd0);
        fwd_rdy_in = 1'b1;
        cyc();
        chk("t4_b_key",  fwd_key_out,      32'h0000_000b);
        chk("t4_b_data", fwd_data_out,     32'h2222_2222);
        chk("t4_b_pld",  32'(fwd_pld_out), 32'd0);
        chk("t4_b_cnt",  32'(fwd_cnt_out), 32'd1);
        chk("t4_b_rdy",  32'(pkt_rdy_out), 32'd1);
        cyc();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t4_c_key", fwd_key_out,      32'h0000_000c);
        chk("t4_c_vld", 32'(fwd_vld_out), 32'd1);
        chk("t4_c_cnt", 32'(fwd_cnt_out), 32'd1);
        cyc();
        chk("t4_empty", 32'(fwd_vld_out), 32'd0);
        chk("t4_c_pop", 32'(fwd_cnt_out), 32'd1);
        cyc();
        chk("t4_cnt_off", 32'(fwd_cnt_out), 32'd0);

        // 5: config packet stalled behind a full FIFO
        fwd_rdy_in = 1'b0;
        drive(32'h0000_00d0, 32'hd0d0_d0d0, 1'b1, 1'b1);
        cyc();
        drive(32'h0000_00e0, 32'he0e0_e0e0, 1'b1, 1'b1);
        cyc();
        drive(32'hffff_fe07, 32'h0000_0077, 1'b1, 1'b1);
        cyc();
        chk("t5_stall_en",  32'(prx_en_out),  32'd0);
        chk("t5_stall_rdy", 32'(pkt_rdy_out), 32'd0);
        cyc();
        chk("t5_stall_en2", 32'(prx_en_out),  32'd0);
        fwd_rdy_in = 1'b1;
        cyc();
        fwd_rdy_in = 1'b0;
        chk("t5_pop_rdy", 32'(pkt_rdy_out), 32'd1);
        chk("t5_pop_en",  32'(prx_en_out),  32'd0);
        chk("t5_pop_key", fwd_key_out,      32'h0000_00e0);
        cyc();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t5_en",    32'(prx_en_out),   32'd1);
        chk("t5_addr",  32'(prx_addr_out), 32'h07);
        chk("t5_wdata", prx_wdata_out,     32'h77);
        chk("t5_fwd",   fwd_key_out,       32'h0000_00e0);

        // 6: reset while full and with a config packet presented
        drive(32'h0000_00f0, 32'hf0f0_f0f0, 1'b1, 1'b1);
        cyc();
        chk("t6_full_rdy", 32'(pkt_rdy_out), 32'd0);
        drive(32'hffff_fe09, 32'h0000_0099, 1'b1, 1'b1);
        reset = 1'b1;
        cyc();
        chk("t6_rst_en",  32'(prx_en_out),  32'd0);
        chk("t6_rst_vld", 32'(fwd_vld_out), 32'd0);
        chk("t6_rst_rdy", 32'(pkt_rdy_out), 32'd1);
        chk("t6_rst_key", fwd_key_out,      32'd0);
        chk("t6_rst_addr", 32'(prx_addr_out), 32'd0);
        // Held reset: the presented config packet must not be taken.
        cyc();
        chk("t6_held_en",  32'(prx_en_out),     32'd0);
        chk("t6_held_wr",  32'(cfg_wr_cnt_out), 32'd0);
        chk("t6_held_rdy", 32'(pkt_rdy_out),    32'd1);
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        fwd_rdy_in = 1'b1;
        cyc();
        chk("t6_post_en",  32'(prx_en_out),  32'd0);
        chk("t6_post_vld", 32'(fwd_vld_out), 32'd0);
        chk("t6_post_rdy", 32'(pkt_rdy_out), 32'd1);
        chk("t6_post_fwdcnt", 32'(fwd_cnt_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hssl_cfg_pkt_rx.md
Name: hssl_cfg_pkt_rx

Overview:
- Packet-receiver stage directly upstream of the register bank.
- Inspects every incoming SpiNNaker multicast packet from the HSSL receive path.
- Configuration packets (key match, payload present) become single-cycle register writes on the prx_* interface consumed by the register bank.
- All other packets go downstream through a 2-entry forwarding FIFO with valid/ready handshake.
- Emits one-cycle pulses for the bank's diagnostic counters.

Parameters:
- ADR_BITS, 8: width of register address driven on prx_addr_out; equals the bank's register address width.
- CFG_KEY, 32'hffff_fe00: configuration routing key.
- CFG_MSK, 32'hffff_ff00: configuration key mask; must cover all bits above ADR_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pkt_key_in  in  32  incoming packet routing key.
- pkt_data_in  in  32  incoming packet payload.
- pkt_pld_in  in  1  payload present.
- pkt_vld_in  in  1  incoming packet valid.
- pkt_rdy_out  out  1  ready to accept an incoming packet.
- fwd_key_out  out  32  forwarded packet key.
- fwd_data_out  out  32  forwarded packet payload.
- fwd_pld_out  out  1  forwarded payload present.
- fwd_vld_out  out  1  forwarded packet valid.
- fwd_rdy_in  in  1  downstream ready.
- prx_addr_out  out  ADR_BITS  register write address, = pkt_key_in[ADR_BITS-1:0].
- prx_wdata_out  out  32  register write data.
- prx_en_out  out  1  register write strobe, one cycle per write.
- cfg_wr_cnt_out  out  1  pulse: one configuration write issued.
- cfg_err_cnt_out  out  1  pulse: configuration packet without payload, dropped.
- fwd_cnt_out  out  1  pulse: one packet forwarded downstream.

Behaviour:
- Input transfer occurs on a cycle with pkt_vld_in && pkt_rdy_out. Output transfer occurs on a cycle with fwd_vld_out && fwd_rdy_in.
- Classification is combinational on the input: cfg = ((pkt_key_in & CFG_MSK) == (CFG_KEY & CFG_MSK)).
- cfg && pkt_pld_in:
  - Accepted in cycle N.
  - Cycle N+1: prx_en_out=1, prx_addr_out=key[ADR_BITS-1:0], prx_wdata_out=pkt_data_in, cfg_wr_cnt_out=1.
  - Not forwarded.
  - Back-to-back config packets give back-to-back strobes.
- cfg && !pkt_pld_in:
  - Accepted and dropped.
  - cfg_err_cnt_out=1 in cycle N+1; no prx_en_out.
- !cfg:
  - Pushed into the forwarding FIFO (key, data, pld).
  - Order preserved.
  - Payload bits are passed through unchanged even when pld=0.
- Forwarding FIFO:
  - 2 entries, registered head drives fwd_*_out.
  - Occupancy count 0..2.
  - fwd_vld_out = (count != 0).
  - Push-to-fwd_vld_out latency: 1 cycle when empty.
  - fwd_cnt_out pulses in the cycle after each output transfer.
- pkt_rdy_out = (count != 2), driven from registered state only; no combinational path from fwd_rdy_in.
  - Config packets are also stalled while the FIFO is full, so all input packets see a uniform handshake.
- Simultaneous push and pop:
  - With count=2: not possible, since pkt_rdy_out=0.
  - With count=1: count stays 1; the new entry becomes head on the next cycle.
- Outputs hold stable while fwd_vld_out && !fwd_rdy_in.
- prx_addr_out and prx_wdata_out hold their last value when prx_en_out=0.
- Reset, effective on the next clk edge:
  - Every output register clears to 0: fwd_*_out, prx_*_out, and all pulse outputs.
  - Count=0; pkt_rdy_out=1 from the first cycle after reset.
- Reset mid-operation:
  - FIFO contents are discarded.
  - A write pending for cycle N+1 is cancelled: no prx_en_out after reset asserts.
  - While reset is held: pkt_rdy_out=1, but nothing is accepted or emitted.

Test Plan:
1. Reset, then packet key=32'hffff_fe03, data=32'h0000_0040, pld=1 -> one cycle later prx_en_out=1, prx_addr_out=8'h03, prx_wdata_out=32'h40, cfg_wr_cnt_out=1; fwd_vld_out stays 0.
2. Key=32'h1234_0001, data=32'hdead_beef, pld=1, fwd_rdy_in=1 -> next cycle fwd_vld_out=1 with identical key/data/pld; fwd_cnt_out=1 the cycle after the transfer; prx_en_out stays 0.
3. Key=32'hffff_fe05, pld=0 -> cfg_err_cnt_out=1 for one cycle; no prx_en_out, no forward.
4. fwd_rdy_in=0, stream of 3 non-config packets A,B,C -> A and B accepted, pkt_rdy_out=0 while C held. Then raise fwd_rdy_in -> A, B, C emerge in order and pkt_rdy_out returns to 1.
5. FIFO full, then a config packet presented -> stalled, no prx_en_out; after one pop it is accepted and strobes a cycle later.
6. Assert reset for 1 cycle while FIFO holds 2 entries and a config write is pending -> no prx_en_out; fwd_vld_out=0, pkt_rdy_out=1 after reset.
